// File: rtl/instr_fetch.sv
// Instruction fetch front end: owns the PC, issues word requests, buffers in-order responses for decode.
// Optional macro INSTR_FETCH_BYPASS_EN forwards a response straight to decode when the buffer is empty.
`timescale 1ns/1ps
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_pc_q    [DEPTH];

    logic          fifo_empty;
    logic          resp_keep;
    logic          bypass;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic [CW:0]   occupancy;

    // Control and decode-facing outputs
    always_comb begin
        fifo_empty     = (count_q == '0);
        occupancy      = {1'b0, count_q} + {1'b0, outstanding_q};
        imem_req_valid = !rst && !redirect_valid && (occupancy < DEPTH_W);
        imem_req_addr  = fetch_pc_q;
        req_fire       = imem_req_valid && imem_req_ready;
        resp_keep      = imem_resp_valid && (discard_q == '0) && !redirect_valid;
`ifdef INSTR_FETCH_BYPASS_EN
        bypass         = !rst && fifo_empty && resp_keep;
`else
        bypass         = 1'b0;
`endif
        instr_valid    = (!fifo_empty || bypass) && !redirect_valid;
        if (!fifo_empty) begin
            instr    = mem_instr_q[rd_ptr_q];
            instr_pc = mem_pc_q[rd_ptr_q];
        end else begin
            instr    = bypass ? imem_resp_data : NOP;
            instr_pc = resp_pc_q;
        end
        pop  = instr_valid && instr_ready && !fifo_empty;
        // A bypassed word consumed by decode this cycle never enters the buffer
        push = resp_keep && !(bypass && instr_ready);
    end

    // Next-state computation
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (req_fire && !imem_resp_valid) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (!req_fire && imem_resp_valid && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - CW'(1);
        end

        if (redirect_valid) begin
            // Every word still in flight after this edge belongs to the old path
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            resp_pc_d  = {redirect_pc[31:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            discard_d  = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_resp_valid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Buffer storage needs no reset: the count alone decides what is visible
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == AW'(gi))) begin
                    mem_instr_q[gi] <= imem_resp_data;
                    mem_pc_q[gi]    <= resp_pc_q;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a memory model answers requests, a monitor checks decode output order.
`timescale 1ns/1ps
module tb_instr_fetch;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef INSTR_FETCH_BYPASS_EN
    localparam logic BYPASS = 1'b1;
`else
    localparam logic BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] next_fetch = 32'h0;
    int          cyc        = 0;
    int          mem_lat    = 1;
    int          delivered  = 0;
    int          vectors    = 0;
    int          miscompares = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Memory model + scoreboard monitor: expectations are pushed at request acceptance
    initial begin
        pend_t p;
        exp_t  e;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                pend_q.delete();
                next_fetch = 32'h0;
            end else begin
                if (imem_req_valid && imem_req_ready) begin
                    check32("req_addr", imem_req_addr, next_fetch);
                    pend_q.push_back('{imem_req_addr, cyc + mem_lat});
                    exp_q.push_back('{next_fetch, memf(next_fetch)});
                    next_fetch = next_fetch + 32'd4;
                end
                if (instr_valid && instr_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_instr: got pc %h instr %h, expected none", instr_pc, instr);
                    end else begin
                        e = exp_q.pop_front();
                        check32("instr_pc", instr_pc, e.pc);
                        check32("instr", instr, e.data);
                        $display("instr pc=%h data=%h", instr_pc, instr);
                        delivered++;
                    end
                end
                if (redirect_valid) begin
                    check32("redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
                    check32("redir_instr_valid", {31'b0, instr_valid}, 32'd0);
                    exp_q.delete();
                    next_fetch = {redirect_pc[31:2], 2'b00};
                end
                vectors++;
                if (exp_q.size() > DEPTH) begin
                    miscompares++;
                    $display("FAIL cap: got %0d in flight+buffered, expected <= %0d", exp_q.size(), DEPTH);
                end
            end
            @(posedge clk);
            #1;
            cyc++;
            if (rst) pend_q.delete();
            if (!rst && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                p = pend_q.pop_front();
                imem_resp_valid = 1'b1;
                imem_resp_data  = memf(p.addr);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = 32'h0;
            end
        end
    end

    task automatic wait_delivered(input int target, input string name);
        int i;
        for (i = 0; i < 200 && delivered < target; i++) @(negedge clk);
        if (delivered < target) timeout(name);
    endtask

    task automatic set_latency(input int lat);
        int i;
        @(posedge clk); #2;
        imem_req_ready = 1'b0;
        for (i = 0; i < 100 && (pend_q.size() != 0 || exp_q.size() != 0); i++) @(negedge clk);
        if (pend_q.size() != 0 || exp_q.size() != 0) timeout("idle_before_latency");
        @(posedge clk); #2;
        mem_lat        = lat;
        imem_req_ready = 1'b1;
    endtask

    initial begin
        bit found;
        rst = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check32("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check32("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check32("rst_instr", instr, NOP);
        check32("rst_instr_pc", instr_pc, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // First response: bypass shows it in the same cycle, otherwise one cycle later
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_resp_valid) found = 1'b1;
        end
        if (!found) timeout("first_resp");
        check32("lat_valid_resp_cycle", {31'b0, instr_valid}, {31'b0, BYPASS});
        check32("lat_instr_resp_cycle", instr, BYPASS ? 32'h0050_0093 : NOP);
        if (!BYPASS) begin
            @(negedge clk);
            check32("lat_valid_next_cycle", {31'b0, instr_valid}, 32'd1);
            check32("lat_instr_next_cycle", instr, 32'h0050_0093);
            check32("lat_pc_next_cycle", instr_pc, 32'h0);
        end
        wait_delivered(8, "stream");

        // Decode stall: buffer fills, issue stops, then drains in order
        @(posedge clk); #2;
        instr_ready = 1'b0;
        repeat (10) @(negedge clk);
        check32("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check32("stall_instr_valid", {31'b0, instr_valid}, 32'd1);
        check32("stall_fill", exp_q.size(), DEPTH);
        @(posedge clk); #2;
        instr_ready = 1'b1;
        wait_delivered(delivered + 6, "drain");

        // Redirect with two requests in flight
        set_latency(3);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (pend_q.size() == 2) found = 1'b1;
        end
        if (!found) timeout("two_in_flight");
        @(posedge clk); #2;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        wait_delivered(delivered + 4, "after_redirect_100");

        // Misaligned redirect coinciding with a response
        set_latency(1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk); #2;
            if (imem_resp_valid) begin
                redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
                found = 1'b1;
            end
        end
        if (!found) timeout("resp_for_redirect");
        @(posedge clk); #2;
        redirect_valid = 1'b0;
        wait_delivered(delivered + 4, "after_redirect_200");

        // Asynchronous reset with the buffer full
        @(posedge clk); #2;
        instr_ready = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (instr_valid && !imem_req_valid && exp_q.size() == DEPTH) found = 1'b1;
        end
        if (!found) timeout("fill_before_reset");
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check32("arst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check32("arst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check32("arst_instr", instr, NOP);
        check32("arst_instr_pc", instr_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        instr_ready = 1'b1;
        wait_delivered(delivered + 4, "after_reset");

        @(posedge clk); #2;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check32("final_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
